// File: rtl/sn74ls373.sv
// -----------------------------------------------------------------------------
// sn74ls373 -- clocked model of an octal D-type transparent latch with 3-state
// outputs (74LS373 style). Used as a bus-interface holding register that
// drives a shared tristate bus.
//
// Parameters:
//   WIDTH  number of data bits (latch word and d/q width), default 8
//
// Ports:
//   clk    rising-edge clock; every state change happens on it
//   rst_n  synchronous reset, active low; clears the stored word and wins over en
//   d      data input, sampled at the edge while en = 1
//   en     latch enable: 1 = transparent (capture every edge), 0 = hold
//   oe     output enable, active low: 0 = drive stored word, 1 = float q
//   q      3-state data output, combinational from oe and the stored word
// -----------------------------------------------------------------------------
module sn74ls373 #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d,
   input  logic             en,
   input  logic             oe,
   output logic [WIDTH-1:0] q
);

   // Stored word; every bit is an independent cell sharing en/oe.
   logic [WIDTH-1:0] latch_q;

   // Latch storage: reset clears, en = 1 captures d, en = 0 holds (d ignored).
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         latch_q <= {WIDTH{1'b0}};
      end else begin
         case (en)
            1'b1:    latch_q <= d;
            1'b0:    latch_q <= latch_q;
            // Unknown enable poisons the whole word so it is visible downstream.
            default: latch_q <= {WIDTH{1'bx}};
         endcase
      end
   end

   // Output buffer: no clock delay, so re-enabling oe shows the stored word at
   // once. An unknown oe merges Z with the data and yields all X.
   assign q = oe ? {WIDTH{1'bz}} : latch_q;

endmodule

// File: tb/tb_sn74ls373.sv
// -----------------------------------------------------------------------------
// tb_sn74ls373 -- scoreboard bench for sn74ls373 (WIDTH = 8 and WIDTH = 4).
// The driver applies inputs on the falling edge and pushes two expectations
// per cycle: one for q just after the inputs change (old stored word, new oe)
// and one for q just after the following rising edge. A separate monitor pops
// and compares at both sample points.
// -----------------------------------------------------------------------------
module tb_sn74ls373;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       en;
   logic       oe;
   logic [7:0] d;
   logic [7:0] q;
   logic [3:0] q4;

   typedef struct {
      logic [7:0] exp;
      bit         isz;
      bit         chk;
      string      tag;
   } entry_t;

   entry_t     sb[$];
   int         checks = 0;
   int         errors = 0;

   // Reference state: the word the device should be holding, and whether it is known.
   logic [7:0] m_word = 8'h00;
   bit         m_known = 1'b0;

   sn74ls373 #(.WIDTH(8)) dut8 (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (d),
      .en    (en),
      .oe    (oe),
      .q     (q)
   );

   sn74ls373 #(.WIDTH(4)) dut4 (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (d[3:0]),
      .en    (en),
      .oe    (oe),
      .q     (q4)
   );

   // Free-running clock, 10 time units per period.
   always #5 clk = ~clk;

   function automatic entry_t expect_q(input logic oe_v, input string tag);
      entry_t e;
      e.tag = tag;
      e.isz = (oe_v === 1'b1);
      e.exp = m_word;
      e.chk = e.isz || ((oe_v === 1'b0) && m_known);
      return e;
   endfunction

   // One cycle of stimulus plus the matching expectations.
   task automatic step(input logic r, input logic e_v, input logic o_v,
                       input logic [7:0] dv, input string tag);
      @(negedge clk);
      rst_n = r;
      en    = e_v;
      oe    = o_v;
      d     = dv;
      sb.push_back(expect_q(o_v, {tag, "/pre"}));
      if (r === 1'b0) begin
         m_word  = 8'h00;
         m_known = 1'b1;
      end else if (e_v === 1'b1) begin
         m_word  = dv;
         m_known = !$isunknown(dv);
      end else if (e_v !== 1'b0) begin
         m_known = 1'b0;
      end
      sb.push_back(expect_q(o_v, {tag, "/post"}));
   endtask

   task automatic check_one();
      entry_t e;
      bit     ok8;
      bit     ok4;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         if (e.chk) begin
            if (e.isz) begin
               // A two-state simulator resolves an undriven bus to zero.
               ok8 = (q === 8'hzz) || (q === 8'h00);
               ok4 = (q4 === 4'hz) || (q4 === 4'h0);
            end else begin
               ok8 = (q === e.exp);
               ok4 = (q4 === e.exp[3:0]);
            end
            checks = checks + 2;
            if (!ok8) begin
               errors = errors + 1;
               $display("FAIL %s q8: got %b expected %b", e.tag, q,
                        e.isz ? 8'hzz : e.exp);
            end
            if (!ok4) begin
               errors = errors + 1;
               $display("FAIL %s q4: got %b expected %b", e.tag, q4,
                        e.isz ? 4'hz : e.exp[3:0]);
            end
         end
      end
   endtask

   // Monitor: samples just after the input change and just after the rising edge.
   initial begin
      forever begin
         @(negedge clk);
         #1;
         check_one();
         @(posedge clk);
         #1;
         check_one();
      end
   end

   // Driver: directed test-plan sequences, then randomized traffic.
   initial begin
      logic       r_v;
      logic       e_v;
      logic       o_v;
      logic [7:0] dv;

      rst_n = 1'b1;
      en    = 1'b0;
      oe    = 1'b1;
      d     = 8'h00;

      step(1'b0, 1'b1, 1'b0, 8'hff, "reset_state");
      for (int i = 0; i < 4; i++) step(1'b1, 1'bx, 1'b1, 8'hxx, "tristate");
      step(1'b1, 1'b1, 1'b0, 8'hff, "pass_ff");
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 8'hxx, "hold_ff");
      step(1'b1, 1'b1, 1'b0, 8'haa, "cap_aa");
      step(1'b1, 1'b0, 1'b0, 8'hxx, "hold_aa");
      step(1'b1, 1'b1, 1'b0, 8'h33, "cap_33");
      step(1'b1, 1'b1, 1'b0, 8'hcc, "track_cc");
      step(1'b1, 1'b0, 1'b0, 8'h00, "hold_cc");
      step(1'b1, 1'b1, 1'b0, 8'haa, "pre_rst_aa");
      step(1'b0, 1'b1, 1'b0, 8'hff, "rst_over_en");
      step(1'b1, 1'b0, 1'b0, 8'hff, "rst_release");
      step(1'b1, 1'b1, 1'b1, 8'h55, "cap_tristated");
      step(1'b1, 1'b0, 1'b1, 8'h00, "hold_tristated");
      step(1'b1, 1'b0, 1'b0, 8'h00, "oe_reenable");
      step(1'b1, 1'b1, 1'b0, 8'h09, "w4_cap_1001");
      step(1'b1, 1'b0, 1'b0, 8'h06, "w4_hold_1001");

      for (int i = 0; i < 300; i++) begin
         r_v = ($urandom_range(0, 19) != 0);
         e_v = ($urandom_range(0, 1) == 1);
         o_v = ($urandom_range(0, 3) == 0);
         dv  = 8'($urandom);
         step(r_v, e_v, o_v, dv, "rand");
      end

      for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
      #2;
      if (sb.size() > 0) begin
         errors = errors + 1;
         $display("FAIL drain: %0d expectations left, required 0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
